// File: rtl/reg_file_16x16_pkg.sv
// Shared sizing for the 16x16 register file and the slice convention of its
// flattened register bus, used by the operand select muxes.
package reg_file_16x16_pkg;

    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int AW   = 4;

    // Register idx occupies bits [DW*idx+DW-1 : DW*idx] of the flat bus.
    function automatic logic [DW-1:0] flat_slice(
        input logic [NREG*DW-1:0] flat,
        input logic [AW-1:0]      idx
    );
        return flat[DW*idx +: DW];
    endfunction

endpackage

// File: rtl/reg_file_16x16_scoreboard.sv
// Busy scoreboard: one reservation bit per register, hazard check against
// same-cycle write-back, and set-over-clear update priority.
module reg_scoreboard #(
    parameter int NREG = reg_file_16x16_pkg::NREG,
    parameter int AW   = reg_file_16x16_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_req,
    input  logic [AW-1:0]   rs1_sel,
    input  logic [AW-1:0]   rs2_sel,
    input  logic            rd_reserve,
    input  logic [AW-1:0]   rd_sel,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_sel,
    output logic            rd_rdy,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] eff_busy_s;
    logic            rdy_s;

    // Hazard check on the busy bits as they will look after this write-back.
    always_comb begin
        clr_mask_s = {NREG{1'b0}};
        set_mask_s = {NREG{1'b0}};
        if (wb_en) begin
            clr_mask_s[wb_sel] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        eff_busy_s = busy_r & ~clr_mask_s;
        rdy_s = ~(eff_busy_s[rs1_sel] | eff_busy_s[rs2_sel] |
                  (rd_reserve & eff_busy_s[rd_sel]));
        // Register 0 is never reserved, so busy[0] stays 0.
        if (rd_req && rdy_s && rd_reserve && (rd_sel != {AW{1'b0}})) begin
            set_mask_s[rd_sel] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
    end

    // Scoreboard update: a reservation set wins over a write-back clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= eff_busy_s | set_mask_s;
        end
    end

    assign rd_rdy = rdy_s;
    assign busy   = busy_r;

endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 register file with zero register, write-back bypass on operand read,
// and a busy scoreboard stalling RAW/WAW hazards.
module reg_file_16x16 #(
    parameter int DW   = reg_file_16x16_pkg::DW,
    parameter int NREG = reg_file_16x16_pkg::NREG,
    parameter int AW   = reg_file_16x16_pkg::AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_req,
    input  logic [AW-1:0]      rs1_sel,
    input  logic [AW-1:0]      rs2_sel,
    input  logic               rd_reserve,
    input  logic [AW-1:0]      rd_sel,
    output logic               rd_rdy,
    output logic [DW-1:0]      rs1_data,
    output logic [DW-1:0]      rs2_data,
    output logic               rd_valid,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_sel,
    input  logic [DW-1:0]      wb_data,
    output logic [NREG-1:0]    busy,
    output logic [NREG*DW-1:0] regs_flat
);
    import reg_file_16x16_pkg::*;

    logic [DW-1:0] regs_r [NREG];
    logic [DW-1:0] rs1_data_r;
    logic [DW-1:0] rs2_data_r;
    logic          rd_valid_r;
    logic [DW-1:0] rs1_byp_s;
    logic [DW-1:0] rs2_byp_s;
    logic          rd_rdy_s;
    logic          accept_s;

    reg_scoreboard #(.NREG(NREG), .AW(AW)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rs1_sel    (rs1_sel),
        .rs2_sel    (rs2_sel),
        .rd_reserve (rd_reserve),
        .rd_sel     (rd_sel),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .rd_rdy     (rd_rdy_s),
        .busy       (busy)
    );

    assign accept_s = rd_req & rd_rdy_s;
    assign rd_rdy   = rd_rdy_s;

    // Register storage; index 0 is never written and therefore reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (wb_en && (wb_sel != {AW{1'b0}})) begin
            regs_r[wb_sel] <= wb_data;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[DW*g +: DW] = regs_r[g];
    end

    // Operand select muxes with bypass of a same-cycle write-back.
    always_comb begin
        rs1_byp_s = flat_slice(regs_flat, rs1_sel);
        rs2_byp_s = flat_slice(regs_flat, rs2_sel);
        if (wb_en && (wb_sel == rs1_sel) && (rs1_sel != {AW{1'b0}})) begin
            rs1_byp_s = wb_data;
        end else begin
            rs1_byp_s = flat_slice(regs_flat, rs1_sel);
        end
        if (wb_en && (wb_sel == rs2_sel) && (rs2_sel != {AW{1'b0}})) begin
            rs2_byp_s = wb_data;
        end else begin
            rs2_byp_s = flat_slice(regs_flat, rs2_sel);
        end
    end

    // Operand capture on accept; operands hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_data_r <= {DW{1'b0}};
            rs2_data_r <= {DW{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (accept_s) begin
            rs1_data_r <= rs1_byp_s;
            rs2_data_r <= rs2_byp_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign rs1_data = rs1_data_r;
    assign rs2_data = rs2_data_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed bench for reg_file_16x16: an array-level model compared every cycle,
// plus literal expectations for the key hazard, bypass and reset scenarios.
module tb_reg_file_16x16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req = 1'b0;
    logic [3:0]   rs1_sel = 4'd0;
    logic [3:0]   rs2_sel = 4'd0;
    logic         rd_reserve = 1'b0;
    logic [3:0]   rd_sel = 4'd0;
    logic         rd_rdy;
    logic [15:0]  rs1_data;
    logic [15:0]  rs2_data;
    logic         rd_valid;
    logic         wb_en = 1'b0;
    logic [3:0]   wb_sel = 4'd0;
    logic [15:0]  wb_data = 16'h0000;
    logic [15:0]  busy;
    logic [255:0] regs_flat;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_16x16 dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rd_reserve(rd_reserve), .rd_sel(rd_sel), .rd_rdy(rd_rdy),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .busy(busy), .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [15:0] m_regs [16];
    bit          m_busy [16];
    bit          m_vld;
    logic [15:0] m_rs1;
    logic [15:0] m_rs2;
    bit          started = 1'b0;

    function automatic bit m_eff(input int k);
        return m_busy[k] && !(wb_en && int'(wb_sel) == k);
    endfunction

    function automatic bit m_rdy();
        return !(m_eff(int'(rs1_sel)) || m_eff(int'(rs2_sel)) ||
                 (rd_reserve && m_eff(int'(rd_sel))));
    endfunction

    function automatic logic [15:0] m_read(input int k);
        if (k == 0) return 16'h0000;
        if (wb_en && int'(wb_sel) == k) return wb_data;
        return m_regs[k];
    endfunction

    // Model update at each rising edge from the inputs applied for that cycle.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = 16'h0000;
                m_busy[i] = 1'b0;
            end
            m_vld = 1'b0;
            m_rs1 = 16'h0000;
            m_rs2 = 16'h0000;
            started = 1'b1;
        end else begin
            bit acc;
            acc = rd_req && m_rdy();
            m_vld = acc;
            if (acc) begin
                m_rs1 = m_read(int'(rs1_sel));
                m_rs2 = m_read(int'(rs2_sel));
            end
            if (wb_en && wb_sel != 4'd0) begin
                m_regs[wb_sel] = wb_data;
                m_busy[wb_sel] = 1'b0;
            end
            if (acc && rd_reserve && rd_sel != 4'd0) m_busy[rd_sel] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (started) begin
            logic [255:0] exp_flat;
            logic [15:0]  exp_busy;
            for (int i = 0; i < 16; i++) begin
                exp_flat[16*i +: 16] = m_regs[i];
                exp_busy[i] = m_busy[i];
            end
            chk("model_rd_rdy", {255'd0, rd_rdy}, {255'd0, m_rdy()});
            chk("model_rd_valid", {255'd0, rd_valid}, {255'd0, m_vld});
            chk("model_rs1", {240'd0, rs1_data}, {240'd0, m_rs1});
            chk("model_rs2", {240'd0, rs2_data}, {240'd0, m_rs2});
            chk("model_busy", {240'd0, busy}, {240'd0, exp_busy});
            chk("model_regs_flat", regs_flat, exp_flat);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = 1'b0; rd_reserve = 1'b0; wb_en = 1'b0;
        rs1_sel = 4'd0; rs2_sel = 4'd0; rd_sel = 4'd0; wb_sel = 4'd0; wb_data = 16'h0000;
    endtask

    task automatic wb(input logic [3:0] sel, input logic [15:0] d);
        wb_en = 1'b1; wb_sel = sel; wb_data = d;
    endtask

    task automatic req(input logic [3:0] r1, input logic [3:0] r2,
                       input logic res, input logic [3:0] rd);
        rd_req = 1'b1; rs1_sel = r1; rs2_sel = r2; rd_reserve = res; rd_sel = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_busy", {240'd0, busy}, 256'd0);
        chk("reset_valid", {255'd0, rd_valid}, 256'd0);
        chk("reset_regs", regs_flat, 256'd0);

        // Write x3, then read it with x0 as second operand.
        wb(4'd3, 16'h1234); step(); idle();
        req(4'd3, 4'd0, 1'b0, 4'd0); #1;
        chk("read_rdy", {255'd0, rd_rdy}, {255'd0, 1'b1});
        step(); idle();
        chk("read_valid", {255'd0, rd_valid}, {255'd0, 1'b1});
        chk("read_rs1", {240'd0, rs1_data}, {240'd0, 16'h1234});
        chk("read_rs2", {240'd0, rs2_data}, 256'd0);
        step();
        chk("hold_valid", {255'd0, rd_valid}, 256'd0);
        chk("hold_rs1", {240'd0, rs1_data}, {240'd0, 16'h1234});

        // Writes to register 0 are ignored.
        wb(4'd0, 16'hFFFF); step(); idle();
        chk("x0_flat", {240'd0, regs_flat[15:0]}, 256'd0);
        chk("x0_busy", {255'd0, busy[0]}, 256'd0);

        // RAW stall on reserved x5, released by its write-back with bypass.
        req(4'd0, 4'd0, 1'b1, 4'd5); step(); idle();
        chk("res5_busy", {255'd0, busy[5]}, {255'd0, 1'b1});
        req(4'd5, 4'd0, 1'b0, 4'd0); #1;
        chk("raw_rdy", {255'd0, rd_rdy}, 256'd0);
        step(); step();
        chk("raw_valid", {255'd0, rd_valid}, 256'd0);
        wb(4'd5, 16'hBEEF); #1;
        chk("wb_rdy", {255'd0, rd_rdy}, {255'd0, 1'b1});
        step(); idle();
        chk("byp_valid", {255'd0, rd_valid}, {255'd0, 1'b1});
        chk("byp_rs1", {240'd0, rs1_data}, {240'd0, 16'hBEEF});
        chk("byp_busy5", {255'd0, busy[5]}, 256'd0);

        // Same-cycle clear and re-reserve of x7: set wins.
        req(4'd0, 4'd0, 1'b1, 4'd7); step(); idle();
        req(4'd0, 4'd0, 1'b1, 4'd7); wb(4'd7, 16'h7777); step(); idle();
        chk("setwin_busy7", {255'd0, busy[7]}, {255'd0, 1'b1});
        chk("setwin_x7", {240'd0, regs_flat[127:112]}, {240'd0, 16'h7777});
        wb(4'd7, 16'h0707); step(); idle();

        // WAW stall on x9: request refused, operands held.
        req(4'd3, 4'd0, 1'b1, 4'd9); step(); idle();
        req(4'd5, 4'd3, 1'b1, 4'd9); #1;
        chk("waw_rdy", {255'd0, rd_rdy}, 256'd0);
        step(); idle();
        chk("waw_valid", {255'd0, rd_valid}, 256'd0);
        chk("waw_rs1", {240'd0, rs1_data}, {240'd0, 16'h1234});
        chk("waw_rs2", {240'd0, rs2_data}, 256'd0);
        wb(4'd9, 16'h0009); step(); idle();

        // Reset mid-operation clears everything, ignoring wb/req in that cycle.
        req(4'd0, 4'd0, 1'b1, 4'd2); wb(4'd4, 16'h00AA); step(); idle();
        chk("pre_busy2", {255'd0, busy[2]}, {255'd0, 1'b1});
        chk("pre_x4", {240'd0, regs_flat[79:64]}, {240'd0, 16'h00AA});
        rst = 1'b1; req(4'd4, 4'd4, 1'b0, 4'd0); wb(4'd6, 16'h6666);
        step(); rst = 1'b0; idle();
        chk("mid_busy", {240'd0, busy}, 256'd0);
        chk("mid_regs", regs_flat, 256'd0);
        chk("mid_valid", {255'd0, rd_valid}, 256'd0);
        chk("mid_rs1", {240'd0, rs1_data}, 256'd0);
        req(4'd2, 4'd0, 1'b1, 4'd2); #1;
        chk("post_rdy", {255'd0, rd_rdy}, {255'd0, 1'b1});
        step(); idle();
        chk("post_valid", {255'd0, rd_valid}, {255'd0, 1'b1});
        chk("post_busy2", {255'd0, busy[2]}, {255'd0, 1'b1});
        wb(4'd2, 16'h2222); step(); idle();

        // Fill all registers, then read pairs; the model checks each cycle.
        for (int i = 1; i < 16; i++) begin
            wb(4'(i), 16'(i * 16'h1011)); step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            req(4'(i), 4'(15 - i), 1'b0, 4'd0); step();
        end
        idle();
        step();
        chk("fill_x15", {240'd0, regs_flat[255:240]}, {240'd0, 16'hF0FF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
